// File: rtl/prog_cnt.sv
// SAP-1 program counter: gate-level (prog_cnt) and behavioural (prog_cnt_bh) views.
// Define PROG_CNT_SATURATE_EN to saturate at all ones instead of wrapping (WRAP tied low).

module prog_cnt #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             CP,
  input  logic             LP,
  input  logic [WIDTH-1:0] D,
  input  logic             HLT,
  input  logic             EP,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] W_BUS,
  output logic             TC,
  output logic             WRAP
);

  logic [WIDTH-1:0] q_q, q_d, inc;
  logic [WIDTH:0]   carry;
  logic             load, cnt, all_ones;

  // Priority decode: HLT masks LP, and LP masks CP.
  assign load = LP & ~HLT;
  assign cnt  = CP & ~LP & ~HLT;

  // Ripple half-adder chain; the final carry doubles as the all-ones detect.
  assign carry[0] = 1'b1;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
`ifdef PROG_CNT_SATURATE_EN
    assign inc[i] = (q_q[i] ^ carry[i]) | all_ones;
`else
    assign inc[i] = q_q[i] ^ carry[i];
`endif
    assign carry[i+1] = carry[i] & q_q[i];
    assign q_d[i] = ~CLR & ((load & D[i]) | (cnt & inc[i]) | (~load & ~cnt & q_q[i]));
  end
  assign all_ones = carry[WIDTH];

  always_ff @(posedge CLK) begin
    q_q <= q_d;
  end

`ifdef PROG_CNT_SATURATE_EN
  assign WRAP = 1'b0;
`else
  logic wrap_q, wrap_d;
  assign wrap_d = ~CLR & cnt & all_ones;
  always_ff @(posedge CLK) begin
    wrap_q <= wrap_d;
  end
  assign WRAP = wrap_q;
`endif

  assign Q     = q_q;
  assign TC    = all_ones & cnt;
  assign W_BUS = EP ? q_q : {WIDTH{1'bz}};

endmodule

module prog_cnt_bh #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             CP,
  input  logic             LP,
  input  logic [WIDTH-1:0] D,
  input  logic             HLT,
  input  logic             EP,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] W_BUS,
  output logic             TC,
  output logic             WRAP
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             at_max;

  assign at_max = &q_q;

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (CLR) begin
      q_d = '0;
    end else if (HLT) begin
      q_d = q_q;
    end else if (LP) begin
      q_d = D;
    end else if (CP) begin
`ifdef PROG_CNT_SATURATE_EN
      q_d = at_max ? q_q : q_q + WIDTH'(1);
`else
      q_d    = q_q + WIDTH'(1);
      wrap_d = at_max;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    q_q    <= q_d;
    wrap_q <= wrap_d;
  end

  assign Q     = q_q;
  assign WRAP  = wrap_q;
  assign TC    = at_max & CP & ~LP & ~HLT;
  assign W_BUS = EP ? q_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_prog_cnt.sv
// Directed bench for prog_cnt, cross-checked against prog_cnt_bh at every sample point.
module tb_prog_cnt;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         clr = 1'b0, cp = 1'b0, lp = 1'b0, hlt = 1'b0, ep = 1'b1;
  logic [W-1:0] d = '0;
  logic [W-1:0] q_g, bus_g, q_b, bus_b;
  logic         tc_g, wrap_g, tc_b, wrap_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] qm;
  logic         wm;

  always #5 clk = ~clk;

  prog_cnt #(.WIDTH(W)) u_gate (
    .CLK(clk), .CLR(clr), .CP(cp), .LP(lp), .D(d), .HLT(hlt), .EP(ep),
    .Q(q_g), .W_BUS(bus_g), .TC(tc_g), .WRAP(wrap_g)
  );

  prog_cnt_bh #(.WIDTH(W)) u_bh (
    .CLK(clk), .CLR(clr), .CP(cp), .LP(lp), .D(d), .HLT(hlt), .EP(ep),
    .Q(q_b), .W_BUS(bus_b), .TC(tc_b), .WRAP(wrap_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected TC and W_BUS derive from the expected Q and the inputs currently applied.
  task automatic chk_all(input string tag, input logic [W-1:0] qe, input logic we);
    logic         tce;
    logic [W-1:0] be;
    tce = (qe == 4'hF) && cp && !lp && !hlt;
    be  = ep ? qe : 4'bzzzz;
    chk({tag, ".q"},      {4'h0, q_g},   {4'h0, qe});
    chk({tag, ".wrap"},   {7'h0, wrap_g}, {7'h0, we});
    chk({tag, ".tc"},     {7'h0, tc_g},  {7'h0, tce});
    chk({tag, ".bus"},    {4'h0, bus_g}, {4'h0, be});
    chk({tag, ".bh_q"},   {4'h0, q_b},   {4'h0, qe});
    chk({tag, ".bh_wrap"},{7'h0, wrap_b}, {7'h0, we});
    chk({tag, ".bh_tc"},  {7'h0, tc_b},  {7'h0, tce});
    chk({tag, ".bh_bus"}, {4'h0, bus_b}, {4'h0, be});
  endtask

  initial begin
    // Reset wins over an active CP.
    clr = 1'b1; cp = 1'b1;
    step();
    clr = 1'b0; cp = 1'b0;
    chk_all("reset", 4'h0, 1'b0);

    // Count 1..5.
    cp = 1'b1;
    step(); chk_all("cnt1", 4'h1, 1'b0);
    step(); chk_all("cnt2", 4'h2, 1'b0);
    step(); chk_all("cnt3", 4'h3, 1'b0);
    step(); chk_all("cnt4", 4'h4, 1'b0);
    step(); chk_all("cnt5", 4'h5, 1'b0);

    // Wrap from E.
    cp = 1'b0; lp = 1'b1; d = 4'hE;
    step(); chk_all("ldE", 4'hE, 1'b0);
    lp = 1'b0; cp = 1'b1;
    chk_all("preE", 4'hE, 1'b0);
    step(); chk_all("wrF", 4'hF, 1'b0);
`ifdef PROG_CNT_SATURATE_EN
    step(); chk_all("sat1", 4'hF, 1'b0);
    step(); chk_all("sat2", 4'hF, 1'b0);
`else
    step(); chk_all("wr0", 4'h0, 1'b1);
    step(); chk_all("wr1", 4'h1, 1'b0);
`endif

    // Load beats count: 9, not A or 4.
    cp = 1'b0; lp = 1'b1; d = 4'h3; ep = 1'b0;
    step(); chk_all("ld3", 4'h3, 1'b0);
    cp = 1'b1; d = 4'h9;
    step(); chk_all("ldpri", 4'h9, 1'b0);

    // Halt freezes despite LP and CP.
    cp = 1'b0; d = 4'h7; ep = 1'b1;
    step(); chk_all("ld7", 4'h7, 1'b0);
    hlt = 1'b1; cp = 1'b1; d = 4'h2;
    step(); chk_all("hlt1", 4'h7, 1'b0);
    step(); chk_all("hlt2", 4'h7, 1'b0);
    step(); chk_all("hlt3", 4'h7, 1'b0);
    hlt = 1'b0; lp = 1'b0;
    step(); chk_all("unhlt", 4'h8, 1'b0);

    // Synchronous reset raised between edges.
    cp = 1'b0; lp = 1'b1; d = 4'h3;
    step(); chk_all("ld3b", 4'h3, 1'b0);
    lp = 1'b0; cp = 1'b1;
    step(); chk_all("c4", 4'h4, 1'b0);
    step(); chk_all("c5", 4'h5, 1'b0);
    clr = 1'b1;
    #2;
    chk_all("clr_wait", 4'h5, 1'b0);
    step(); chk_all("clr_edge", 4'h0, 1'b0);
    clr = 1'b0;

    // Sweep all {LP, D} with CP=1 and EP toggling, against a small model.
    qm = 4'h0; wm = 1'b0;
    for (int i = 0; i < 32; i++) begin
      d  = i[3:0];
      lp = i[4];
      cp = 1'b1;
      ep = i[0];
      if (lp) begin
        qm = d; wm = 1'b0;
      end else begin
`ifdef PROG_CNT_SATURATE_EN
        wm = 1'b0;
        if (qm != 4'hF) qm = qm + 4'h1;
`else
        wm = (qm == 4'hF);
        qm = qm + 4'h1;
`endif
      end
      step();
      chk_all("sweep", qm, wm);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_cnt.md
Name: prog_cnt

Overview:
- SAP-1 program counter: holds the address of the next instruction and increments on each fetch.
- Sits directly upstream of the buffer register; Q drives the buffer register's X input; the W-bus copy feeds the MAR during T1.
- Adds a synchronous parallel load (jump path for SAP-2 reuse), a halt freeze, a terminal-count flag and a registered wrap pulse.

Parameters:
- WIDTH, 4, counter/address width in bits; must be >= 2.

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- CLR  input  1  synchronous active-high reset; sampled on the rising edge of CLK.
- CP  input  1  count enable; increment Q by 1 on the next edge.
- LP  input  1  parallel load enable; Q <= D on the next edge.
- D  input  WIDTH  parallel load value (jump target).
- HLT  input  1  halt; freezes Q and WRAP while high.
- EP  input  1  output enable for the W-bus driver.
- Q  output  WIDTH  registered count; always driven; feeds buffer register X.
- W_BUS  output  WIDTH  equals Q when EP=1, all bits high-impedance when EP=0.
- TC  output  1  combinational terminal count: 1 when Q is all ones and CP=1 and LP=0 and HLT=0.
- WRAP  output  1  registered one-cycle pulse, high for the cycle after Q rolled from all ones to 0 by counting.

Behaviour:
- Reset: a rising edge with CLR=1 gives Q=0 and WRAP=0 at that edge, regardless of all other inputs. Outputs after reset:
  - Q=0, WRAP=0.
  - TC follows its equation.
  - W_BUS follows EP.
- Reset is synchronous only: asserting CLR between edges changes nothing until the next rising edge.
- Priority per rising edge, highest first: CLR, HLT, LP, CP, hold.
- HLT=1 (CLR=0): Q holds, WRAP <= 0. LP and CP are ignored.
- LP=1 (CLR=0, HLT=0): Q <= D, WRAP <= 0. A simultaneous CP is ignored; the load wins and there is no increment of D.
- CP=1 only: Q <= Q+1 modulo 2^WIDTH. WRAP <= 1 exactly when the old Q was all ones, otherwise 0.
- No enables asserted: Q holds, WRAP <= 0.
- Latency: one clock from enable to new Q. W_BUS and TC are combinational from current state and inputs, with zero latency.
- Arithmetic: unsigned WIDTH-bit increment. The carry is not stored except through WRAP.
- Loading all ones and then counting wraps normally and produces a WRAP pulse.
- Reset mid-count or mid-load: CLR overrides at that edge and the count restarts from 0 on the next CP.
- X or Z on the control inputs is not a supported condition; the bench drives known values only.
- Two implementations are required, with identical ports and cycle behaviour:
  - prog_cnt: gate-level, built from the codebase's D flip-flop and gate primitives.
  - prog_cnt_bh: behavioural.

Optional Feature:
- Macro: PROG_CNT_SATURATE_EN.
- Defined:
  - With CP only and Q all ones, Q holds at all ones instead of wrapping.
  - WRAP stays 0 permanently (tied low).
  - TC still asserts under the same equation, signalling "at limit".
  - Load and reset are unchanged.
- Undefined: modulo wrap-around and WRAP pulse exactly as in Behaviour.

Test Plan (WIDTH=4):
- Reset and count:
  - Stimulus: CLR=1 for one edge, then CP=1 for 5 edges.
  - Response: Q=0 after reset, then 1,2,3,4,5; WRAP=0 throughout.
- Wrap:
  - Stimulus: load D=4'hE, then CP=1 for 3 edges.
  - Response: Q=E,F,0,1.
  - TC=1 only while Q=F with CP=1.
  - WRAP=1 only in the cycle Q=0.
  - With PROG_CNT_SATURATE_EN instead: Q=E,F,F,F and WRAP=0.
- Load priority:
  - Stimulus: Q=3, LP=1, CP=1, D=4'h9 on one edge.
  - Response: Q=9, not A and not 4; WRAP=0.
- Halt:
  - Stimulus: Q=7, HLT=1 with CP=1 and LP=1 (D=2) for 3 edges, then HLT=0 with CP=1.
  - Response: Q stays 7 for 3 edges, then 8.
- Sync reset mid-operation:
  - Stimulus: CP=1 counting, CLR raised 1 ns after an edge with Q=5.
  - Response: Q stays 5 until the next rising edge, then 0, overriding CP; WRAP=0.
- Bus driver and equivalence:
  - Stimulus: EP toggled while counting over all 32 {D, LP} combinations with CP=1.
  - Response: W_BUS=4'bzzzz when EP=0 and W_BUS=Q when EP=1.
  - prog_cnt and prog_cnt_bh outputs are identical at every sample point.
